adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8, operand/sum width in bits.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have port REQ_VALID  input  NREQ  per-requester request valid.
REQ-006 SHALL have port REQ_READY  output  NREQ  per-requester accept strobe, combinational.
REQ-007 SHALL have port REQ_A  input  NREQ*W  packed operand A; slice i belongs to requester i.
REQ-008 SHALL have port REQ_B  input  NREQ*W  packed operand B; slice i belongs to requester i.
REQ-009 SHALL have port REQ_CIN  input  NREQ  per-requester carry-in.
REQ-010 SHALL have port RSP_VALID  output  1  result valid.
REQ-011 SHALL have port RSP_READY  input  1  downstream accepts result.
REQ-012 SHALL have port RSP_ID  output  clog2(NREQ)  index of the requester owning the result.
REQ-013 SHALL have port RSP_SUM  output  W  sum bits.
REQ-014 SHALL have port RSP_COUT  output  1  carry-out.

Function
REQ-015 Arbiter SHALL share one W-bit adder among NREQ requesters with a two-stage pipeline: S1 holds granted operands, CIN and ID; S2 holds {COUT,SUM} and ID.
REQ-016 Pipeline SHALL advance (ADV=1) iff S2 empty or RSP_READY=1; when ADV=0, S1, S2 and the priority pointer SHALL hold.
REQ-017 When ADV=1, arbiter SHALL grant the first requester with REQ_VALID=1 searching circularly from pointer PTR; at most one REQ_READY bit SHALL be high per cycle.
REQ-018 REQ_READY[i] SHALL be 1 iff ADV=1 and requester i is granted; a transfer occurs when REQ_VALID[i] and REQ_READY[i] are both 1.
REQ-019 After a transfer from requester i, PTR SHALL become (i+1) mod NREQ; with no transfer PTR SHALL hold.
REQ-020 Requesters SHALL hold REQ_VALID and operands stable until accepted; arbiter SHALL not rely on retraction.
REQ-021 S2 result SHALL equal REQ_A slice + REQ_B slice + REQ_CIN, width W+1, with bit W on RSP_COUT, no truncation error.
REQ-022 Latency SHALL be exactly 2 cycles from transfer edge to RSP_VALID=1 when unstalled; throughput SHALL be one result per cycle.
REQ-023 RSP_VALID and RSP_ID/RSP_SUM/RSP_COUT SHALL remain stable while RSP_VALID=1 and RSP_READY=0.
REQ-024 Results SHALL emerge in grant order; no result SHALL be dropped or duplicated under any RSP_READY pattern.
REQ-025 When ADV=1, S1 SHALL move to S2 and a new grant SHALL load S1 in the same cycle; S1 with no grant SHALL become empty.
REQ-026 With all REQ_VALID low, S1 SHALL drain to S2 and then to output; PTR SHALL hold.
REQ-027 With a single requester continuously valid, it SHALL be granted every cycle ADV=1.

Reset
REQ-028 RST_N low SHALL asynchronously clear S1/S2 valid flags, PTR to 0, RSP_VALID, RSP_ID, RSP_SUM, RSP_COUT to 0.
REQ-029 Reset mid-operation SHALL discard all in-flight results; REQ_READY SHALL be 0 while RST_N is low.
REQ-030 First grant SHALL be possible on the first posedge after RST_N deasserts.

Structure
REQ-031 A shared package SHALL hold the default NREQ and W constants and the ID-width function.
REQ-032 Priority selection SHALL be a sub-module rr_arbiter (inputs valid vector, PTR, enable; outputs one-hot grant and encoded ID).
REQ-033 Implementation SHALL be 120-400 lines of RTL, synchronous except for reset.

Verification
REQ-034 Single: req0 A=0x12,B=0x34,CIN=1, RSP_READY=1 -> 2 cycles later RSP_VALID=1, ID=0, SUM=0x47, COUT=0.
REQ-035 Overflow: req2 A=0xFF,B=0x01,CIN=1 -> SUM=0x01, COUT=1, ID=2.
REQ-036 Fairness: all 4 valid continuously, PTR=0 after reset -> grant order 0,1,2,3,0,1 on consecutive cycles, results in same ID order.
REQ-037 Backpressure: 3 back-to-back transfers, RSP_READY=0 for 5 cycles then 1 -> output holds first result, REQ_READY all 0 while stalled, all 3 results delivered in order, none lost.
REQ-038 Reset: assert RST_N low with 2 results in flight -> RSP_VALID=0 immediately, PTR=0, no stale result after release.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared constants and helpers for the round-robin shared-adder arbiter.
package adder_arbiter_pkg;
    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;

    // Width of a requester index; never below one bit so ports stay legal.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/adder_arbiter_rr.sv
// Round-robin priority select: first valid requester at or after i_ptr, circularly.
module rr_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IW   = id_w(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IW-1:0]   i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_id,
    output logic            o_any
);
    int w_idx;

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (i_en && !o_any && i_valid[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_id           = IW'(w_idx);
            end
        end
    end
endmodule

// File: rtl/adder_arbiter.sv
// One W-bit adder shared by NREQ requesters: grant -> S1 (operands) -> S2 (sum) -> output.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int W    = W_DEF,
    localparam int IW   = id_w(NREQ)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [NREQ-1:0] REQ_VALID,
    output logic [NREQ-1:0] REQ_READY,
    input  logic [NREQ*W-1:0] REQ_A,
    input  logic [NREQ*W-1:0] REQ_B,
    input  logic [NREQ-1:0] REQ_CIN,
    output logic            RSP_VALID,
    input  logic            RSP_READY,
    output logic [IW-1:0]   RSP_ID,
    output logic [W-1:0]    RSP_SUM,
    output logic            RSP_COUT
);
    logic [NREQ-1:0][W-1:0] w_a, w_b;
    logic                   w_adv, w_any;
    logic [NREQ-1:0]        w_gnt;
    logic [IW-1:0]          w_gnt_id, w_ptr_nxt;
    logic [W:0]             w_res;

    logic          r_s1_v, r_s1_cin, r_s2_v;
    logic [W-1:0]  r_s1_a, r_s1_b;
    logic [IW-1:0] r_s1_id, r_s2_id, r_ptr;
    logic [W:0]    r_s2_res;

    assign w_a   = REQ_A;
    assign w_b   = REQ_B;
    assign w_adv = !r_s2_v || RSP_READY;

    // Gating with RST_N keeps REQ_READY low for the whole reset window.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_valid (REQ_VALID),
        .i_ptr   (r_ptr),
        .i_en    (w_adv && RST_N),
        .o_grant (w_gnt),
        .o_id    (w_gnt_id),
        .o_any   (w_any)
    );

    assign REQ_READY = w_gnt;
    assign w_ptr_nxt = (w_gnt_id == IW'(NREQ-1)) ? '0 : w_gnt_id + 1'b1;
    assign w_res     = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {{W{1'b0}}, r_s1_cin};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_v   <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_cin <= 1'b0;
            r_s1_id  <= '0;
            r_s2_v   <= 1'b0;
            r_s2_id  <= '0;
            r_s2_res <= '0;
            r_ptr    <= '0;
        end else if (w_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_id  <= r_s1_id;
                r_s2_res <= w_res;
            end
            r_s1_v <= w_any;
            if (w_any) begin
                r_s1_a   <= w_a[w_gnt_id];
                r_s1_b   <= w_b[w_gnt_id];
                r_s1_cin <= REQ_CIN[w_gnt_id];
                r_s1_id  <= w_gnt_id;
                r_ptr    <= w_ptr_nxt;
            end
        end
    end

    assign RSP_VALID = r_s2_v;
    assign RSP_ID    = r_s2_id;
    assign RSP_SUM   = r_s2_res[W-1:0];
    assign RSP_COUT  = r_s2_res[W];
endmodule
